// File: rtl/db_pkg.sv
// Shared definitions for the hash-table key/value store: op/response codes,
// FSM states, value-field layout and the bit-serial CRC-32 step.
package db_pkg;

  localparam int KEY_LEN = 96;
  localparam int VAL_LEN = 32;

  localparam logic [3:0] OP_LOOKUP = 4'd1;
  localparam logic [3:0] OP_INSERT = 4'd2;
  localparam logic [3:0] OP_DELETE = 4'd3;

  localparam logic [3:0] RSP_HIT      = 4'd1;
  localparam logic [3:0] RSP_MISS     = 4'd2;
  localparam logic [3:0] RSP_INSERTED = 4'd3;
  localparam logic [3:0] RSP_REPLACED = 4'd4;
  localparam logic [3:0] RSP_UPDATED  = 4'd5;
  localparam logic [3:0] RSP_DELETED  = 4'd6;
  localparam logic [3:0] RSP_DEL_MISS = 4'd7;
  localparam logic [3:0] RSP_ERROR    = 4'd15;

  // Layout of the stored value word as used by the filter path
  localparam int VAL_STATUS_HI = 31;
  localparam int VAL_STATUS_LO = 28;
  localparam int VAL_FLAG_HI   = 27;
  localparam int VAL_FLAG_LO   = 24;
  localparam int VAL_TIME_HI   = 23;
  localparam int VAL_TIME_LO   = 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_HASH,
    ST_READ,
    ST_RESOLVE,
    ST_RESP
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic data_bit);
    crc32_bit = {crc[30:0], 1'b0} ^ (((crc[31] ^ data_bit) == 1'b1) ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/db_hash_table_if.sv
// Request/response bundle between a requester (master) and the hash table (slave).
interface db_hash_table_if #(
  parameter int KEY_SIZE  = 96,
  parameter int VAL_SIZE  = 32,
  parameter int RAM_ADDR  = 10,
  parameter int FLAG_SIZE = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [FLAG_SIZE-1:0] in_op;
  logic [KEY_SIZE-1:0]  in_key;
  logic [VAL_SIZE-1:0]  in_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [FLAG_SIZE-1:0] out_flag;
  logic [VAL_SIZE-1:0]  out_value;
  logic [RAM_ADDR:0]    occupancy;

  modport master (
    output in_valid, in_op, in_key, in_value, out_ready,
    input  in_ready, out_valid, out_flag, out_value, occupancy
  );

  modport slave (
    input  in_valid, in_op, in_key, in_value, out_ready,
    output in_ready, out_valid, out_flag, out_value, occupancy
  );
endinterface

// File: rtl/db_hash_crc32.sv
// CRC-32 (poly 0x04C11DB7, init all-ones, MSB first, no reflection, no final XOR)
// over the whole key, registered when en is high.
module db_hash_crc32
  import db_pkg::*;
#(
  parameter int KEY_SIZE = KEY_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [KEY_SIZE-1:0] key,
  output logic [31:0]         crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = CRC_INIT;
    for (int i = KEY_SIZE - 1; i >= 0; i--) begin
      crc_next = crc32_bit(crc_next, key[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/db_hash_table.sv
// Direct-mapped key/value table indexed by CRC-32 of the key; one request in
// flight, table cleared by a sweep after every reset.
module db_hash_table
  import db_pkg::*;
#(
  parameter int KEY_SIZE  = KEY_LEN,
  parameter int VAL_SIZE  = VAL_LEN,
  parameter int RAM_ADDR  = 10,
  parameter int FLAG_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst,
  db_hash_table_if.slave bus
);

  localparam int ENTRY_W = 1 + KEY_SIZE + VAL_SIZE;
  localparam int DEPTH   = 2 ** RAM_ADDR;

  state_t               state_reg, state_next;
  logic [RAM_ADDR-1:0]  cnt_reg, cnt_next;
  logic [FLAG_SIZE-1:0] op_reg;
  logic [KEY_SIZE-1:0]  key_reg;
  logic [VAL_SIZE-1:0]  val_reg;
  logic [FLAG_SIZE-1:0] flag_reg, flag_next;
  logic [VAL_SIZE-1:0]  value_reg, value_next;
  logic [RAM_ADDR:0]    occ_reg, occ_next;
  logic                 capture, crc_en;

  logic [31:0]          crc;
  logic                 crc_unused;
  logic [RAM_ADDR-1:0]  index;

  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   rd_data, ram_wdata;
  logic [RAM_ADDR-1:0]  ram_addr;
  logic                 ram_we, ram_re;
  logic                 rd_vld, hit;
  logic [KEY_SIZE-1:0]  rd_key;
  logic [VAL_SIZE-1:0]  rd_val;

  db_hash_crc32 #(.KEY_SIZE(KEY_SIZE)) u_crc (
    .clk (clk),
    .rst (rst),
    .en  (crc_en),
    .key (key_reg),
    .crc (crc)
  );

  // Only the low bits select a bucket; the rest of the CRC is intentionally dropped
  assign index      = crc[RAM_ADDR-1:0];
  assign crc_unused = ^crc[31:RAM_ADDR];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    if (ram_re) begin
      rd_data <= mem[ram_addr];
    end
  end

  assign rd_vld = rd_data[ENTRY_W-1];
  assign rd_key = rd_data[VAL_SIZE +: KEY_SIZE];
  assign rd_val = rd_data[VAL_SIZE-1:0];
  assign hit    = rd_vld && (rd_key == key_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
      op_reg    <= '0;
      key_reg   <= '0;
      val_reg   <= '0;
      flag_reg  <= '0;
      value_reg <= '0;
      occ_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      flag_reg  <= flag_next;
      value_reg <= value_next;
      occ_reg   <= occ_next;
      if (capture) begin
        op_reg  <= bus.in_op;
        key_reg <= bus.in_key;
        val_reg <= bus.in_value;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    flag_next  = flag_reg;
    value_next = value_reg;
    occ_next   = occ_reg;
    capture    = 1'b0;
    crc_en     = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = index;
    ram_wdata  = '0;
    case (state_reg)
      ST_INIT: begin
        ram_addr = cnt_reg;
        ram_we   = 1'b1;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == {RAM_ADDR{1'b1}}) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.in_valid) begin
          capture    = 1'b1;
          state_next = ST_HASH;
        end
      end
      ST_HASH: begin
        crc_en     = 1'b1;
        state_next = ST_READ;
      end
      ST_READ: begin
        ram_re     = 1'b1;
        state_next = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        state_next = ST_RESP;
        value_next = '0;
        case (op_reg)
          FLAG_SIZE'(OP_LOOKUP): begin
            flag_next = hit ? FLAG_SIZE'(RSP_HIT) : FLAG_SIZE'(RSP_MISS);
            if (hit) value_next = rd_val;
          end
          FLAG_SIZE'(OP_INSERT): begin
            ram_we    = 1'b1;
            ram_wdata = {1'b1, key_reg, val_reg};
            if (!rd_vld) begin
              flag_next = FLAG_SIZE'(RSP_INSERTED);
              occ_next  = occ_reg + 1'b1;
            end else if (hit) begin
              flag_next = FLAG_SIZE'(RSP_UPDATED);
            end else begin
              // Collision: evict the resident key, report what was lost
              flag_next  = FLAG_SIZE'(RSP_REPLACED);
              value_next = rd_val;
            end
          end
          FLAG_SIZE'(OP_DELETE): begin
            if (hit) begin
              ram_we     = 1'b1;
              flag_next  = FLAG_SIZE'(RSP_DELETED);
              value_next = rd_val;
              occ_next   = occ_reg - 1'b1;
            end else begin
              flag_next = FLAG_SIZE'(RSP_DEL_MISS);
            end
          end
          default: flag_next = FLAG_SIZE'(RSP_ERROR);
        endcase
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_RESP);
  assign bus.out_flag  = flag_reg;
  assign bus.out_value = value_reg;
  assign bus.occupancy = occ_reg;

endmodule

// File: tb/tb_db_hash_table.sv
// Randomised bench for db_hash_table (16-entry table) against a table model
// with its own bytewise CRC; one response line per transaction.
module tb_db_hash_table;
  import db_pkg::*;

  localparam int KW = 96, VW = 32, AW = 4, FW = 4, DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  db_hash_table_if #(.KEY_SIZE(KW), .VAL_SIZE(VW), .RAM_ADDR(AW), .FLAG_SIZE(FW)) bus ();

  db_hash_table #(.KEY_SIZE(KW), .VAL_SIZE(VW), .RAM_ADDR(AW), .FLAG_SIZE(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [FW-1:0] flag;
    logic [VW-1:0] value;
    logic [AW:0]   occ;
  } exp_t;

  exp_t          exp_q[$];
  logic          m_vld [DEPTH];
  logic [KW-1:0] m_key [DEPTH];
  logic [VW-1:0] m_val [DEPTH];
  int            n_cmp = 0, n_bad = 0, n_txn = 0;
  logic [FW-1:0] last_flag;
  logic [VW-1:0] last_value;
  logic [AW:0]   last_occ;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no progress within cycle budget (t=%0t)", name, $time);
  endtask

  // Reference CRC processed a byte at a time, most significant byte first
  function automatic logic [31:0] model_crc(input logic [KW-1:0] k, input int nbytes);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int b = nbytes - 1; b >= 0; b--) begin
      c = c ^ {k[b*8 +: 8], 24'h0};
      for (int i = 0; i < 8; i++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c;
  endfunction

  function automatic int slot_of(input logic [KW-1:0] k);
    logic [31:0] c = model_crc(k, 12);
    return int'(c[AW-1:0]);
  endfunction

  function automatic logic [AW:0] model_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_vld[i]) n++;
    return (AW + 1)'(n);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_key[i] = '0;
      m_val[i] = '0;
    end
  endtask

  task automatic model_apply(input logic [FW-1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v);
    int   s = slot_of(k);
    logic present = m_vld[s] && (m_key[s] == k);
    exp_t e;
    e.value = '0;
    if (op == OP_LOOKUP) begin
      e.flag = present ? RSP_HIT : RSP_MISS;
      if (present) e.value = m_val[s];
    end else if (op == OP_INSERT) begin
      if (!m_vld[s]) e.flag = RSP_INSERTED;
      else if (present) e.flag = RSP_UPDATED;
      else begin
        e.flag  = RSP_REPLACED;
        e.value = m_val[s];
      end
      m_vld[s] = 1'b1;
      m_key[s] = k;
      m_val[s] = v;
    end else if (op == OP_DELETE) begin
      e.flag = present ? RSP_DELETED : RSP_DEL_MISS;
      if (present) begin
        e.value  = m_val[s];
        m_vld[s] = 1'b0;
      end
    end else begin
      e.flag = RSP_ERROR;
    end
    e.occ = model_occ();
    exp_q.push_back(e);
  endtask

  // Response checker: every cycle a response is presented it must match the model
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        bound_fail("unexpected_out_valid");
      end else begin
        chk("out_flag", bus.out_flag, exp_q[0].flag);
        chk("out_value", bus.out_value, exp_q[0].value);
        chk("occupancy", bus.occupancy, exp_q[0].occ);
        chk("in_ready_while_busy", bus.in_ready, 0);
        if (bus.out_ready) begin
          last_flag  = bus.out_flag;
          last_value = bus.out_value;
          last_occ   = bus.occupancy;
          n_txn++;
          $display("txn %0d: flag=%0d value=%08h occupancy=%0d", n_txn, bus.out_flag,
                   bus.out_value, bus.occupancy);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send_req(input logic [FW-1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v,
                          input bit release_ready, output int waits);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_key   = k;
    bus.in_value = v;
    if (release_ready) bus.out_ready = 1'b1;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.in_ready && waits < 200);
    if (!bus.in_ready) bound_fail("accept_timeout");
    else model_apply(op, k, v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit bp);
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
      if (bp) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    if (exp_q.size() != 0) bound_fail("response_timeout");
    exp_q.delete();
    bus.out_ready = 1'b1;
  endtask

  task automatic req(input logic [FW-1:0] op, input logic [KW-1:0] k, input logic [VW-1:0] v, input bit bp);
    int w;
    send_req(op, k, v, 1'b0, w);
    wait_resp(bp);
  endtask

  task automatic init_count(output int c);
    c = 0;
    while (!bus.in_ready && c < 100) begin
      c++;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_flag", bus.out_flag, 0);
    chk("rst_out_value", bus.out_value, 0);
    chk("rst_occupancy", bus.occupancy, 0);
  endtask

  logic [KW-1:0] k1, k2, k3, k5, pin_key;
  logic [KW-1:0] pool [8];
  logic [FW-1:0] op;
  int            cnt, waits, held, r, guard;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_key    = '0;
    bus.in_value  = '0;
    bus.out_ready = 1'b1;
    model_clear();

    // Pin the reference CRC against the catalogue check value of "123456789"
    pin_key = {24'h0, "123456789"};
    chk("model_crc_check", model_crc(pin_key, 9), 32'h0376E6E7);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    init_count(cnt);
    chk("init_ready_low_cycles", cnt, 16);
    chk("init_occupancy", bus.occupancy, 0);

    // Empty table
    req(OP_LOOKUP, {$urandom, $urandom, $urandom}, 32'h0, 1'b0);
    chk("t1_lookup_flag", last_flag, RSP_MISS);
    chk("t1_lookup_value", last_value, 0);

    // Insert / hit / update
    k1 = {$urandom, $urandom, $urandom};
    req(OP_INSERT, k1, 32'hDEADBEEF, 1'b0);
    chk("t2_insert_flag", last_flag, RSP_INSERTED);
    chk("t2_insert_occ", last_occ, 1);
    req(OP_LOOKUP, k1, 32'h0, 1'b0);
    chk("t2_lookup_flag", last_flag, RSP_HIT);
    chk("t2_lookup_value", last_value, 32'hDEADBEEF);
    req(OP_INSERT, k1, 32'h12345678, 1'b0);
    chk("t2_update_flag", last_flag, RSP_UPDATED);
    chk("t2_update_occ", last_occ, 1);

    // Collision on the same bucket
    guard = 0;
    do begin
      k2 = {$urandom, $urandom, $urandom};
      guard++;
    end while ((slot_of(k2) != slot_of(k1) || k2 == k1) && guard < 10000);
    req(OP_INSERT, k2, 32'hCAFEF00D, 1'b0);
    chk("t3_replace_flag", last_flag, RSP_REPLACED);
    chk("t3_replace_value", last_value, 32'h12345678);
    chk("t3_replace_occ", last_occ, 1);
    req(OP_LOOKUP, k1, 32'h0, 1'b0);
    chk("t3_evicted_lookup", last_flag, RSP_MISS);

    // Delete paths and illegal op
    req(OP_INSERT, k1, 32'h11112222, 1'b0);
    chk("t4_reinsert_value", last_value, 32'hCAFEF00D);
    req(OP_DELETE, k1, 32'h0, 1'b0);
    chk("t4_delete_flag", last_flag, RSP_DELETED);
    chk("t4_delete_value", last_value, 32'h11112222);
    chk("t4_delete_occ", last_occ, 0);
    req(OP_DELETE, k1, 32'h0, 1'b0);
    chk("t4_del_miss_flag", last_flag, RSP_DEL_MISS);
    req(4'd7, k2, 32'h55AA55AA, 1'b0);
    chk("t4_error_flag", last_flag, RSP_ERROR);
    chk("t4_error_value", last_value, 0);
    req(OP_LOOKUP, k2, 32'h0, 1'b0);
    chk("t4_table_unchanged", last_flag, RSP_MISS);

    // Backpressure hold, then back-to-back accept
    k3 = {$urandom, $urandom, $urandom};
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send_req(OP_INSERT, k3, 32'hA5A5_0001, 1'b0, waits);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.out_valid && guard < 50);
    held = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) held++;
    end
    chk("t5_held_cycles", held, 10);
    send_req(OP_LOOKUP, k3, 32'h0, 1'b1, waits);
    chk("t5_accept_after_release", waits, 2);
    wait_resp(1'b0);
    chk("t5_lookup_flag", last_flag, RSP_HIT);
    chk("t5_lookup_value", last_value, 32'hA5A5_0001);

    // Random traffic over a small key pool that includes a colliding pair
    pool[0] = k1;
    pool[1] = k2;
    for (int i = 2; i < 8; i++) pool[i] = {$urandom, $urandom, $urandom};
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = OP_LOOKUP;
      else if (r < 7) op = OP_INSERT;
      else if (r < 9) op = OP_DELETE;
      else op = FW'($urandom_range(4, 15));
      req(op, pool[$urandom_range(0, 7)], $urandom, 1'b1);
    end

    // Reset while an insert is in its READ cycle
    req(OP_INSERT, k3, 32'h0BAD_0BAD, 1'b0);
    k5 = {$urandom, $urandom, $urandom};
    send_req(OP_INSERT, k5, 32'h7777_8888, 1'b0, waits);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    init_count(cnt);
    chk("t6_init_ready_low_cycles", cnt, 16);
    req(OP_LOOKUP, k5, 32'h0, 1'b0);
    chk("t6_lookup_flag", last_flag, RSP_MISS);
    chk("t6_lookup_occ", last_occ, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
